// File: rtl/share_collector.sv
// share_collector: compares sampled hashes against the compact-nBits target,
// recovers the originating {time,nonce} and queues hits for the host.
module share_collector #(
  parameter int PIPE_LAT = 128,
  parameter int DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     hash_valid,
  input  logic [255:0]             hash_in,
  input  logic [63:0]              cnt_in,
  input  logic                     tgt_load,
  input  logic [31:0]              tgt_bits,
  output logic                     share_valid,
  input  logic                     share_ready,
  output logic [31:0]              share_time,
  output logic [31:0]              share_nonce,
  output logic [31:0]              share_hash_hi,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [31:0]              hash_count,
  output logic [31:0]              share_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [255:0]   v, tgt, tgt_next, m_ext;
  logic [7:0]     e;
  logic           sample, pop, full, push_ok;
  logic           s1_hit;
  logic [63:0]    s1_rec;
  logic [31:0]    s1_hi;
  logic [95:0]    mem [DEPTH];
  logic [95:0]    head_next;
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_next;
  logic [LW-1:0]  level_next;
  for (genvar b = 0; b < 32; b++) begin : g_rev
    assign v[8*b +: 8] = hash_in[255-8*b -: 8];
  end
  assign e     = tgt_bits[31:24];
  assign m_ext = {232'b0, tgt_bits[23:0]};
  always_comb
    tgt_next = (e > 8'd32) ? '1 :
               (e >= 8'd3) ? m_ext << (8 * (e - 8'd3)) :
                             m_ext >> (8 * (8'd3 - e));
  assign sample      = en & hash_valid;
  assign share_valid = fifo_level != '0;
  assign full        = fifo_level == LW'(DEPTH);
  assign pop         = share_valid & share_ready;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok     = s1_hit & (~full | pop);
  assign rd_next     = rd_ptr + AW'(pop);
  assign level_next  = fifo_level + LW'(push_ok) - LW'(pop);
  // the only entry not yet in memory is the one being pushed into an otherwise empty FIFO
  assign head_next   = (push_ok && wr_ptr == rd_next) ? {s1_rec, s1_hi} : mem[rd_next];
  always_ff @(posedge CLK)
    if (!clear && push_ok) mem[wr_ptr] <= {s1_rec, s1_hi};
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      tgt           <= '0;
      s1_hit        <= 1'b0;
      s1_rec        <= '0;
      s1_hi         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_level    <= '0;
      overflow      <= 1'b0;
      hash_count    <= '0;
      share_count   <= '0;
      share_time    <= '0;
      share_nonce   <= '0;
      share_hash_hi <= '0;
    end else begin
      if (tgt_load) tgt <= tgt_next;
      if (clear) begin
        s1_hit      <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        fifo_level  <= '0;
        overflow    <= 1'b0;
        hash_count  <= '0;
        share_count <= '0;
      end else begin
        s1_hit      <= sample && (v <= tgt);
        s1_rec      <= cnt_in - 64'(PIPE_LAT);
        s1_hi       <= v[255:224];
        hash_count  <= hash_count + 32'(sample);
        share_count <= share_count + 32'(s1_hit);
        overflow    <= overflow | (s1_hit & ~push_ok);
        wr_ptr      <= wr_ptr + AW'(push_ok);
        rd_ptr      <= rd_next;
        fifo_level  <= level_next;
        if (level_next != '0) {share_time, share_nonce, share_hash_hi} <= head_next;
      end
    end
endmodule
